// File: rtl/riscv_pkg.sv
// Shared types for the memory stage: memory-control encoding, access sizes and M-stage FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_t;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } mem_size_t;

    typedef struct packed {
        mem_op_t   op;
        mem_size_t size;
    } mem_ctrl_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_WAIT = 2'b10
    } ms_state_t;

    // Halfwords need an even address, words a 4-byte aligned one; unknown sizes are treated as words.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_B, SIZE_BU: mis = 1'b0;
            SIZE_H, SIZE_HU: mis = addr_lo[0];
            default:         mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic is_mem_op(input mem_op_t op);
        return (op == MEM_LOAD) || (op == MEM_STORE);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data bus: store enables/replication and load extraction/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  mem_size_t   i_size,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load,
    output logic        o_misalign
);

    logic [31:0] w_lane;

    assign w_lane     = i_rdata >> {i_addr_lo, 3'b000};
    assign o_misalign = is_misaligned(i_size, i_addr_lo);

    // Lane selection for both directions, keyed on the access size.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
        o_load  = 32'h0000_0000;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_sdata[7:0]}};
                o_load  = {{24{w_lane[7]}}, w_lane[7:0]};
            end
            SIZE_BU: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_sdata[7:0]}};
                o_load  = {24'h00_0000, w_lane[7:0]};
            end
            SIZE_H: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_sdata[15:0]}};
                o_load  = {{16{w_lane[15]}}, w_lane[15:0]};
            end
            SIZE_HU: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_sdata[15:0]}};
                o_load  = {16'h0000, w_lane[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_sdata;
                o_load  = w_lane;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M pipeline stage: E/M register, data-bus handshake FSM, stall generation and writeback selection.
module memory_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  mem_ctrl_e,
    input  logic        reg_we_e,
    input  logic [4:0]  rd_e,
    input  logic        bubble_e,
    input  logic [31:0] exec_res_e,
    input  logic [31:0] fwd_b_e,
    output logic [31:0] exec_res_m,
    output logic [31:0] reg_d_m,
    output logic        reg_we_m,
    output logic [4:0]  rd_m,
    output logic        stall_m,
    output logic        misalign_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    mem_ctrl_t   w_ctrl_e;
    logic        w_capture_mem;
    logic        w_stall;
    logic        w_m_mem;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;
    logic        w_misalign;

    logic        r_valid;
    mem_ctrl_t   r_ctrl;
    logic        r_reg_we;
    logic [4:0]  r_rd;
    logic [31:0] r_res;
    logic [31:0] r_sdata;
    ms_state_t   r_state;
    ms_state_t   w_state_nxt;

    assign w_ctrl_e      = mem_ctrl_t'(mem_ctrl_e);
    assign w_capture_mem = !bubble_e && is_mem_op(w_ctrl_e.op)
                           && !is_misaligned(w_ctrl_e.size, exec_res_e[1:0]);
    assign w_m_mem       = r_valid && is_mem_op(r_ctrl.op);

    lsu_align u_lsu_align (
        .i_addr_lo  (r_res[1:0]),
        .i_size     (r_ctrl.size),
        .i_sdata    (r_sdata),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_load     (w_load),
        .o_misalign (w_misalign)
    );

    // E/M pipeline register; frozen while an access is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_ctrl   <= '{op: MEM_NONE, size: SIZE_B};
            r_reg_we <= 1'b0;
            r_rd     <= 5'd0;
            r_res    <= 32'h0000_0000;
            r_sdata  <= 32'h0000_0000;
        end else if (!w_stall) begin
            r_valid  <= !bubble_e;
            r_ctrl   <= w_ctrl_e;
            r_reg_we <= reg_we_e;
            r_rd     <= rd_e;
            r_res    <= exec_res_e;
            r_sdata  <= fwd_b_e;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: on completion, jump straight to REQ when the incoming instruction is a memory op.
    always_comb begin
        w_state_nxt = MS_IDLE;
        case (r_state)
            MS_IDLE: w_state_nxt = w_capture_mem ? MS_REQ : MS_IDLE;
            MS_REQ: begin
                if (!dmem_gnt) begin
                    w_state_nxt = MS_REQ;
                end else if (r_ctrl.op == MEM_LOAD) begin
                    w_state_nxt = MS_WAIT;
                end else begin
                    w_state_nxt = w_capture_mem ? MS_REQ : MS_IDLE;
                end
            end
            MS_WAIT: begin
                if (dmem_rvalid) begin
                    w_state_nxt = w_capture_mem ? MS_REQ : MS_IDLE;
                end else begin
                    w_state_nxt = MS_WAIT;
                end
            end
            default: w_state_nxt = MS_IDLE;
        endcase
    end

    // Outputs: bus request fields, stall, and the writeback value/enable.
    always_comb begin
        w_stall    = ((r_state == MS_REQ) && (!dmem_gnt || (r_ctrl.op == MEM_LOAD)))
                     || ((r_state == MS_WAIT) && !dmem_rvalid);
        dmem_req   = (r_state == MS_REQ);
        dmem_we    = dmem_req && (r_ctrl.op == MEM_STORE);
        dmem_addr  = {r_res[31:2], 2'b00};
        dmem_be    = dmem_req ? w_be : 4'b0000;
        dmem_wdata = dmem_req ? w_wdata : 32'h0000_0000;
        misalign_m = w_m_mem && w_misalign;
        reg_d_m    = (r_ctrl.op == MEM_LOAD) ? w_load : r_res;
        reg_we_m   = r_valid && r_reg_we && !w_stall && !misalign_m
                     && (r_ctrl.op != MEM_STORE)
                     && ((r_ctrl.op != MEM_LOAD) || (r_state == MS_WAIT));
    end

    assign stall_m    = w_stall;
    assign exec_res_m = r_res;
    assign rd_m       = r_rd;

endmodule

// File: tb/tb_memory_stage.sv
// Directed and randomized checks of memory_stage against a size/offset-arithmetic reference model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  mem_ctrl_e;
    logic        reg_we_e;
    logic [4:0]  rd_e;
    logic        bubble_e;
    logic [31:0] exec_res_e;
    logic [31:0] fwd_b_e;
    logic [31:0] exec_res_m;
    logic [31:0] reg_d_m;
    logic        reg_we_m;
    logic [4:0]  rd_m;
    logic        stall_m;
    logic        misalign_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .mem_ctrl_e(mem_ctrl_e), .reg_we_e(reg_we_e), .rd_e(rd_e),
        .bubble_e(bubble_e), .exec_res_e(exec_res_e), .fwd_b_e(fwd_b_e), .exec_res_m(exec_res_m),
        .reg_d_m(reg_d_m), .reg_we_m(reg_we_m), .rd_m(rd_m), .stall_m(stall_m),
        .misalign_m(misalign_m), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes from funct3[1:0].
    function automatic int nbytes(input logic [2:0] f3);
        logic [1:0] sz;
        sz = f3[1:0];
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = nbytes(f3);
        return 4'(((1 << n) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int n;
        n = nbytes(f3);
        if (n == 1) return (d % 256) * 32'h0101_0101;
        if (n == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint v;
        int n;
        n = nbytes(f3);
        v = longint'(rdata >> (8 * (addr % 4)));
        if (n == 4) return rdata;
        v = v % (longint'(1) << (8 * n));
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic drive_bubble();
        mem_ctrl_e = 5'b00000; reg_we_e = 1'b0; rd_e = 5'd0; bubble_e = 1'b1;
        exec_res_e = 32'h0; fwd_b_e = 32'h0;
    endtask

    task automatic drive_e(input logic [1:0] op, input logic [2:0] f3, input logic we,
                           input logic [4:0] rd, input logic [31:0] res, input logic [31:0] d);
        mem_ctrl_e = {op, f3}; reg_we_e = we; rd_e = rd; bubble_e = 1'b0;
        exec_res_e = res; fwd_b_e = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated instruction through M with the given grant/rvalid delays; returns stall-cycle count.
    task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic we,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] d,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           output int stall_cnt);
        bit is_mem, mis, last, exp_req;
        int total;
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        mis = is_mem && ref_mis(f3, addr);
        stall_cnt = 0;
        drive_e(op, f3, we, rd, addr, d);
        step();
        drive_bubble();
        if (!is_mem || mis) begin
            @(negedge clk);
            chk("misalign", 32'(misalign_m), 32'(mis));
            chk("req_idle", 32'(dmem_req), 32'd0);
            chk("stall_idle", 32'(stall_m), 32'd0);
            chk("we_nonmem", 32'(reg_we_m), 32'(!mis && we));
            chk("rd_nonmem", 32'(rd_m), 32'(rd));
            if (!mis) chk("regd_alu", reg_d_m, addr);
            step();
            chk("misalign_clear", 32'(misalign_m), 32'd0);
        end else begin
            total = (op == OP_LOAD) ? gnt_dly + 2 + rv_dly : gnt_dly + 1;
            for (int k = 0; k < total; k++) begin
                last = (k == total - 1);
                exp_req = (k <= gnt_dly);
                dmem_gnt = (k == gnt_dly) ? 1'b1 : ((k > gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0);
                dmem_rvalid = (op == OP_LOAD) && last;
                dmem_rdata = last ? rdata : $urandom;
                @(negedge clk);
                if (stall_m) stall_cnt++;
                chk("req", 32'(dmem_req), 32'(exp_req));
                chk("stall", 32'(stall_m), 32'(!last));
                chk("misalign_mem", 32'(misalign_m), 32'd0);
                chk("reg_we_mem", 32'(reg_we_m), 32'(last && op == OP_LOAD && we));
                if (exp_req) begin
                    chk("dmem_we", 32'(dmem_we), 32'(op == OP_STORE));
                    chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                    chk("dmem_be", 32'(dmem_be), 32'(ref_be(f3, addr)));
                    if (op == OP_STORE) chk("dmem_wdata", dmem_wdata, ref_wdata(f3, d));
                end
                if (last && op == OP_LOAD) begin
                    chk("load_data", reg_d_m, ref_load(f3, addr, rdata));
                    chk("load_rd", 32'(rd_m), 32'(rd));
                end
                step();
            end
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
        end
    endtask

    initial begin
        int sc;
        logic [1:0] op;
        logic [2:0] f3;
        logic [2:0] ld_codes [5];
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst_n = 1'b0;
        drive_bubble();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        step(); step();
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall_m), 32'd0);
        chk("rst_regwe", 32'(reg_we_m), 32'd0);
        chk("rst_res", exec_res_m, 32'd0);
        chk("rst_regd", reg_d_m, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset while a load waits for rvalid.
        drive_e(OP_LOAD, 3'b010, 1'b1, 5'd3, 32'h0000_0100, 32'h0);
        step();
        drive_bubble();
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("pre_rst_req", 32'(dmem_req), 32'd1);
        step();
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", 32'(stall_m), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req), 32'd0);
        chk("midrst_stall", 32'(stall_m), 32'd0);
        step();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("postrst_req", 32'(dmem_req), 32'd0);
        chk("postrst_stall", 32'(stall_m), 32'd0);
        chk("postrst_regwe", 32'(reg_we_m), 32'd0);
        step();
        dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("postrst_idle", 32'(stall_m), 32'd0);
        step();

        // Directed cases.
        run_txn(OP_STORE, 3'b000, 1'b0, 5'd0, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, sc);
        chk("sb_stall_cnt", 32'(sc), 32'd0);
        run_txn(OP_LOAD, 3'b001, 1'b1, 5'd5, 32'h0000_2002, 32'h0, 2, 0, 32'h8001_1234, sc);
        chk("lh_stall_cnt", 32'(sc), 32'd3);
        run_txn(OP_LOAD, 3'b101, 1'b1, 5'd6, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234, sc);
        run_txn(OP_LOAD, 3'b100, 1'b1, 5'd7, 32'h0000_2001, 32'h0, 0, 1, 32'h8001_1234, sc);
        chk("lbu_stall_cnt", 32'(sc), 32'd2);
        run_txn(OP_LOAD, 3'b010, 1'b1, 5'd8, 32'h0000_3002, 32'h0, 0, 0, 32'h0, sc);
        chk("lw_mis_stall_cnt", 32'(sc), 32'd0);

        // Back-to-back SW then LW, then ALU/bubble mix behind the load.
        drive_e(OP_STORE, 3'b010, 1'b0, 5'd0, 32'h0000_0040, 32'hCAFE_F00D);
        step();
        drive_e(OP_LOAD, 3'b010, 1'b1, 5'd9, 32'h0000_0044, 32'h0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk("b2b_sw_req", 32'(dmem_req), 32'd1);
        chk("b2b_sw_we", 32'(dmem_we), 32'd1);
        chk("b2b_sw_wdata", dmem_wdata, 32'hCAFE_F00D);
        chk("b2b_sw_stall", 32'(stall_m), 32'd0);
        step();
        drive_e(OP_NONE, 3'b000, 1'b1, 5'd10, 32'h0000_0055, 32'h0);
        @(negedge clk);
        chk("b2b_lw_req", 32'(dmem_req), 32'd1);
        chk("b2b_lw_we", 32'(dmem_we), 32'd0);
        chk("b2b_lw_addr", dmem_addr, 32'h0000_0044);
        chk("b2b_lw_stall", 32'(stall_m), 32'd1);
        step();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("b2b_lw_done", 32'(stall_m), 32'd0);
        chk("b2b_lw_regwe", 32'(reg_we_m), 32'd1);
        chk("b2b_lw_data", reg_d_m, 32'hDEAD_BEEF);
        step();
        dmem_rvalid = 1'b0;
        drive_e(OP_NONE, 3'b000, 1'b1, 5'd11, 32'h0000_0066, 32'h0);
        bubble_e = 1'b1;
        @(negedge clk);
        chk("add_regwe", 32'(reg_we_m), 32'd1);
        chk("add_regd", reg_d_m, 32'h0000_0055);
        chk("add_rd", 32'(rd_m), 32'd10);
        step();
        drive_e(OP_NONE, 3'b000, 1'b0, 5'd12, 32'h0000_0077, 32'h0);
        @(negedge clk);
        chk("bubble_regwe", 32'(reg_we_m), 32'd0);
        step();
        drive_bubble();
        @(negedge clk);
        chk("nowe_regwe", 32'(reg_we_m), 32'd0);
        step();

        // Randomized transactions.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 2));
            if (op == OP_STORE) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_codes[$urandom_range(0, 4)];
            run_txn(op, f3, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom, sc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
